seq_multiplier: RTL



---
 rtl/mult_pkg.sv | 15 +
 rtl/seq_multiplier.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must be able to hold the value WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH cycles per product, valid/ready on both
// sides, signed or unsigned mode captured with the operands.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t          state_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [WIDTH-1:0] mag_a_q;
   logic [WIDTH-1:0] mag_b_q;
   logic            neg_q;
   logic [PW-1:0]   acc_q;
   logic [PW-1:0]   product_q;
   logic [CW-1:0]   cnt_q;

   logic            accept_s;
   logic            last_s;
   logic [WIDTH-1:0] mag_a_d;
   logic [WIDTH-1:0] mag_b_d;
   logic            neg_d;
   logic [WIDTH:0]  sum_d;
   logic [PW-1:0]   acc_d;
   logic [PW-1:0]   product_d;

   // Next-state datapath values: operand magnitudes, one accumulate/shift step, sign fix-up.
   always_comb begin
      accept_s  = in_valid & in_ready_q;
      last_s    = (cnt_q == LAST_CNT);
      mag_a_d   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      mag_b_d   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      neg_d     = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      sum_d     = mag_b_q[0] ? ({1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mag_a_q})
                             : {1'b0, acc_q[PW-1:WIDTH]};
      // The carry out of the upper half lands in the MSB after the shift.
      acc_d     = PW'({sum_d, acc_q[WIDTH-1:0]} >> 1'b1);
      product_d = neg_q ? (~acc_d + PW'(1)) : acc_d;
   end

   // Control FSM with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  state_q    <= CALC;
                  in_ready_q <= 1'b0;
               end
            end
            CALC: begin
               if (last_s) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Operand capture, accumulate/shift iterations and result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  mag_a_q <= mag_a_d;
                  mag_b_q <= mag_b_d;
                  neg_q   <= neg_d;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            CALC: begin
               acc_q   <= acc_d;
               mag_b_q <= mag_b_q >> 1'b1;
               cnt_q   <= cnt_q + CW'(1);
               if (last_s) begin
                  product_q <= product_d;
               end
            end
            DONE: begin
               product_q <= product_q;
            end
            default: begin
               acc_q <= '0;
               cnt_q <= '0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign product   = product_q;

endmodule
